rcv_ctrl: RTL and testbench

//  Receive control unit for the serial receiver. Sequences its bit-period timer and its bit counter.

---
 rtl/rcv_ctrl.sv | 135 +++++++++++++
 tb/tb_rcv_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/rcv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rcv_ctrl
// Description : Receive control unit for the serial receiver. Runs the
//               bit-period timer and the bit counter. It starts on a detected
//               start bit and issues one shift strobe per bit period for the
//               data and stop bits. It then checks the stop bit and either
//               loads the RX buffer or raises a sticky framing error.
// Revision    : 1.0 - initial release
// ============================================================================
module rcv_ctrl #(
    parameter int CLKS_PER_BIT  = 10,
    parameter int NUM_DATA_BITS = 8
) (
    input  logic                                  clk,
    input  logic                                  n_rst,
    input  logic                                  start_bit_detected,
    input  logic                                  stop_bit,
    input  logic                                  rcv_abort,
    output logic                                  shift_strobe,
    output logic                                  load_buffer,
    output logic                                  framing_error,
    output logic                                  busy,
    output logic [$clog2(NUM_DATA_BITS+2)-1:0]    bit_count
);

    localparam int c_TIMER_W = $clog2(CLKS_PER_BIT + 1);
    localparam int c_COUNT_W = $clog2(NUM_DATA_BITS + 2);

    localparam logic [c_TIMER_W-1:0] c_TIMER_MAX  = c_TIMER_W'(CLKS_PER_BIT);
    localparam logic [c_TIMER_W-1:0] c_TIMER_ONE  = c_TIMER_W'(1);
    localparam logic [c_COUNT_W-1:0] c_LAST_DATA  = c_COUNT_W'(NUM_DATA_BITS);
    localparam logic [c_COUNT_W-1:0] c_COUNT_ONE  = c_COUNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CLEAR    = 3'd1,
        ST_RECEIVE  = 3'd2,
        ST_STOP_CHK = 3'd3,
        ST_LOAD     = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_TIMER_W-1:0]   r_timer;
    logic [c_TIMER_W-1:0]   w_timer_nxt;
    logic [c_COUNT_W-1:0]   r_bit_count;
    logic [c_COUNT_W-1:0]   w_bit_count_nxt;
    logic                   r_framing_error;
    logic                   w_framing_error_nxt;
    logic                   w_shift_strobe;
    logic                   w_load_buffer;

    // State, timer, bit counter and sticky error registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state         <= ST_IDLE;
            r_timer         <= '0;
            r_bit_count     <= '0;
            r_framing_error <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_timer         <= w_timer_nxt;
            r_bit_count     <= w_bit_count_nxt;
            r_framing_error <= w_framing_error_nxt;
        end
    end

    // Next-state and strobe decode; abort overrides every state decision
    always_comb begin
        w_state_nxt         = r_state;
        w_timer_nxt         = r_timer;
        w_bit_count_nxt     = r_bit_count;
        w_framing_error_nxt = r_framing_error;
        w_shift_strobe      = 1'b0;
        w_load_buffer       = 1'b0;

        if (rcv_abort) begin
            w_state_nxt     = ST_IDLE;
            w_timer_nxt     = '0;
            w_bit_count_nxt = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_bit_detected) begin
                        w_state_nxt = ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    w_timer_nxt         = '0;
                    w_bit_count_nxt     = '0;
                    w_framing_error_nxt = 1'b0;
                    w_state_nxt         = ST_RECEIVE;
                end
                ST_RECEIVE: begin
                    if (r_timer == c_TIMER_MAX) begin
                        // Timer restarts at 1 so each following period is
                        // exactly CLKS_PER_BIT cycles long.
                        w_shift_strobe  = 1'b1;
                        w_timer_nxt     = c_TIMER_ONE;
                        w_bit_count_nxt = r_bit_count + c_COUNT_ONE;
                        if (r_bit_count == c_LAST_DATA) begin
                            w_state_nxt = ST_STOP_CHK;
                        end
                    end else begin
                        w_timer_nxt = r_timer + c_TIMER_ONE;
                    end
                end
                ST_STOP_CHK: begin
                    if (stop_bit) begin
                        w_state_nxt = ST_LOAD;
                    end else begin
                        w_framing_error_nxt = 1'b1;
                        w_state_nxt         = ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    w_load_buffer = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign shift_strobe  = w_shift_strobe;
    assign load_buffer   = w_load_buffer;
    assign framing_error = r_framing_error;
    assign busy          = (r_state != ST_IDLE);
    assign bit_count     = r_bit_count;

endmodule
`default_nettype wire

// File: tb/tb_rcv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rcv_ctrl
// Description : Self-checking bench for rcv_ctrl. Two instances share the
//               same stimulus: one with the default parameters (10/8) and
//               one with the minimum parameters (2/1). Each instance has a
//               reference model that tracks time elapsed since the start bit
//               was accepted.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rcv_ctrl;

    logic       clk;
    logic       n_rst;
    logic       start_bit_detected;
    logic       stop_bit;
    logic       rcv_abort;

    logic       ss0, lb0, fe0, busy0;
    logic [3:0] bc0;
    logic       ss1, lb1, fe1, busy1;
    logic [1:0] bc1;

    int n_checks;
    int n_errors;
    int cyc;

    // Reference model state per instance: m_e = cycles since start accepted
    // (0 = idle), m_bc = strobes issued this frame, m_fe = sticky error.
    int cpb [2];
    int nb  [2];
    int m_e [2];
    int m_bc[2];
    bit m_fe[2];
    int m_t0[2];

    rcv_ctrl #(.CLKS_PER_BIT(10), .NUM_DATA_BITS(8)) u_dut0 (
        .clk                (clk),
        .n_rst              (n_rst),
        .start_bit_detected (start_bit_detected),
        .stop_bit           (stop_bit),
        .rcv_abort          (rcv_abort),
        .shift_strobe       (ss0),
        .load_buffer        (lb0),
        .framing_error      (fe0),
        .busy               (busy0),
        .bit_count          (bc0)
    );

    rcv_ctrl #(.CLKS_PER_BIT(2), .NUM_DATA_BITS(1)) u_dut1 (
        .clk                (clk),
        .n_rst              (n_rst),
        .start_bit_detected (start_bit_detected),
        .stop_bit           (stop_bit),
        .rcv_abort          (rcv_abort),
        .shift_strobe       (ss1),
        .load_buffer        (lb1),
        .framing_error      (fe1),
        .busy               (busy1),
        .bit_count          (bc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    function automatic int last_strobe(input int d);
        return 2 + (nb[d] + 1) * cpb[d];
    endfunction

    function automatic bit exp_strobe(input int d, input bit ab);
        return !ab && (m_e[d] >= 2 + cpb[d]) && (m_e[d] <= last_strobe(d))
               && (((m_e[d] - 2) % cpb[d]) == 0);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_e[d]  = 0;
            m_bc[d] = 0;
            m_fe[d] = 1'b0;
        end
    endtask

    task automatic check_outputs(input bit ab);
        int obs_ss, obs_lb, obs_fe, obs_busy, obs_bc;
        for (int d = 0; d < 2; d++) begin
            obs_ss   = (d == 0) ? int'(ss0)   : int'(ss1);
            obs_lb   = (d == 0) ? int'(lb0)   : int'(lb1);
            obs_fe   = (d == 0) ? int'(fe0)   : int'(fe1);
            obs_busy = (d == 0) ? int'(busy0) : int'(busy1);
            obs_bc   = (d == 0) ? int'(bc0)   : int'(bc1);
            check($sformatf("d%0d.shift_strobe", d), obs_ss, int'(exp_strobe(d, ab)));
            check($sformatf("d%0d.load_buffer", d), obs_lb,
                  int'(!ab && m_e[d] == last_strobe(d) + 2));
            check($sformatf("d%0d.framing_error", d), obs_fe, int'(m_fe[d]));
            check($sformatf("d%0d.busy", d), obs_busy, int'(m_e[d] != 0));
            check($sformatf("d%0d.bit_count", d), obs_bc, m_bc[d]);
            // Absolute load latency from the accepted start bit
            if (obs_lb == 1) begin
                check($sformatf("d%0d.load_latency", d), cyc - m_t0[d],
                      2 + (nb[d] + 1) * cpb[d] + 2);
            end
        end
    endtask

    task automatic model_advance(input bit st, input bit sb, input bit ab);
        for (int d = 0; d < 2; d++) begin
            if (ab) begin
                m_e[d]  = 0;
                m_bc[d] = 0;
            end else if (m_e[d] == 0) begin
                if (st) begin
                    m_e[d]  = 1;
                    m_t0[d] = cyc;
                end
            end else if (m_e[d] == 1) begin
                m_fe[d] = 1'b0;
                m_bc[d] = 0;
                m_e[d]  = 2;
            end else if (exp_strobe(d, 1'b0)) begin
                m_bc[d]++;
                m_e[d]++;
            end else if (m_e[d] == last_strobe(d) + 1) begin
                if (!sb) begin
                    m_fe[d] = 1'b1;
                    m_e[d]  = 0;
                end else begin
                    m_e[d]++;
                end
            end else if (m_e[d] == last_strobe(d) + 2) begin
                m_e[d] = 0;
            end else begin
                m_e[d]++;
            end
        end
    endtask

    // One clock cycle: apply inputs, check outputs mid-cycle, advance the model
    task automatic step(input bit st, input bit sb, input bit ab);
        @(negedge clk);
        start_bit_detected = st;
        stop_bit           = sb;
        rcv_abort          = ab;
        #1;
        check_outputs(ab);
        @(posedge clk);
        model_advance(st, sb, ab);
        cyc++;
    endtask

    // Asynchronous reset asserted between clock edges
    task automatic async_reset();
        @(negedge clk);
        #2;
        start_bit_detected = 1'b0;
        stop_bit           = 1'b0;
        rcv_abort          = 1'b0;
        n_rst              = 1'b0;
        #1;
        model_reset();
        check_outputs(1'b0);
        repeat (2) begin
            @(posedge clk);
            cyc++;
        end
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        cpb[0] = 10; nb[0] = 8;
        cpb[1] = 2;  nb[1] = 1;
        m_t0[0] = 0; m_t0[1] = 0;
        model_reset();

        n_rst              = 1'b0;
        start_bit_detected = 1'b0;
        stop_bit           = 1'b0;
        rcv_abort          = 1'b0;
        #1;
        check_outputs(1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_rst = 1'b1;

        // Good frame
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 99; i++) step(1'b0, 1'b1, 1'b0);

        // Bad stop bit, then a good frame that clears the error at CLEAR
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 99; i++) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 99; i++) step(1'b0, 1'b1, 1'b0);

        // Abort mid-frame at t0+50
        step(1'b1, 1'b1, 1'b0);
        for (int i = 1; i < 50; i++) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0);

        // Ignored mid-frame start, then back-to-back frame at t0+95
        step(1'b1, 1'b1, 1'b0);
        for (int i = 1; i <= 94; i++) step(i == 40, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 110; i++) step(1'b0, 1'b1, 1'b0);

        // Async reset in the middle of RECEIVE
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 30; i++) step(1'b0, 1'b1, 1'b0);
        async_reset();
        for (int i = 0; i < 30; i++) step(1'b0, 1'b1, 1'b0);

        // Randomised traffic
        for (int i = 0; i < 4000; i++) begin
            step(($urandom % 6) == 0, ($urandom % 4) != 0, ($urandom % 150) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
